iir_dac_spi_tx: RTL and testbench

Output stage of the IIR filter chain. It consumes the 12-bit signed filter output once per sample strobe and serialises it to an external 12-bit SPI DAC as a 16-bit frame. The frame is 4 command bits followed by 12 offset-binary data bits. A one-entry holding register decouples the sample rate from the SPI frame time, and any sample that gets overwritten is counted as an overrun.

---
 rtl/iir_dac_spi_tx.sv | 168 ++++++++++++++++
 tb/tb_iir_dac_spi_tx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_dac_spi_tx.sv
`default_nettype none
// ============================================================================
//  Module   : iir_dac_spi_tx
//  Purpose  : Output stage of the IIR filter chain. Takes one 12-bit signed
//             sample per sample_en strobe into a one-entry holding register,
//             converts it to offset binary and shifts it out to a 12-bit SPI
//             DAC as a 16-bit frame {CMD, data}, MSB first. Samples that get
//             overwritten before transmission are counted (saturating).
//  Ports    : sys_clk     - system clock
//             sys_rst     - asynchronous, active-low reset
//             Din         - 12-bit signed filter sample
//             sample_en   - one-cycle strobe, Din valid in that cycle
//             dac_cs_n    - DAC chip select, active low
//             dac_sclk    - SPI clock, idles low
//             dac_sdo     - SPI serial data, MSB first
//             busy        - high from frame start until the CS gap ends
//             overrun_cnt - saturating count of overwritten samples
//  Revision : 1.0 - initial release
// ============================================================================
module iir_dac_spi_tx #(
    parameter int         CLK_DIV = 2,        // sys_clk cycles per SCLK half-period
    parameter logic [3:0] CMD     = 4'b0011,  // DAC command nibble
    parameter int         CS_GAP  = 4         // min cs_n high cycles between frames
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [11:0] Din,
    input  logic        sample_en,
    output logic        dac_cs_n,
    output logic        dac_sclk,
    output logic        dac_sdo,
    output logic        busy,
    output logic [7:0]  overrun_cnt
);

    // One counter serves both the SCLK half-periods and the CS gap, so it
    // must be wide enough for whichever is longer.
    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] C_GAP_LAST  = CNT_W'(CS_GAP - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]       C_LAST_BIT  = 4'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t           r_state;
    logic [11:0]      r_hold;
    logic             r_hold_valid;
    logic [15:0]      r_shift;
    logic [CNT_W-1:0] r_half_cnt;
    logic [3:0]       r_bit_cnt;

    logic             w_consume;
    logic [15:0]      w_frame;

    // Flipping the sign bit maps two's complement onto offset binary.
    assign w_frame   = {CMD, r_hold ^ 12'h800};
    assign w_consume = (r_state == IDLE) && r_hold_valid;

    // ------------------------------------------------------------------
    // Holding register. A new strobe always wins; it is an overrun only if
    // the previous sample is still pending and not being taken this edge.
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_hold       <= 12'h000;
            r_hold_valid <= 1'b0;
            overrun_cnt  <= 8'd0;
        end else if (sample_en) begin
            r_hold       <= Din;
            r_hold_valid <= 1'b1;
            if (r_hold_valid && !w_consume && (overrun_cnt != 8'hFF)) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
        end else if (w_consume) begin
            r_hold_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer. All SPI pins are driven from flops so the DAC never
    // sees decode glitches. The phase within a bit is the current dac_sclk
    // level itself.
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state    <= IDLE;
            r_shift    <= 16'h0000;
            r_half_cnt <= '0;
            r_bit_cnt  <= 4'd0;
            dac_cs_n   <= 1'b1;
            dac_sclk   <= 1'b0;
            dac_sdo    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_hold_valid) begin
                        r_shift    <= w_frame;
                        dac_sdo    <= w_frame[15];
                        dac_cs_n   <= 1'b0;
                        busy       <= 1'b1;
                        r_half_cnt <= '0;
                        r_state    <= SETUP;
                    end
                end

                SETUP: begin
                    if (r_half_cnt == C_HALF_LAST) begin
                        r_half_cnt <= '0;
                        r_bit_cnt  <= 4'd0;
                        dac_sclk   <= 1'b1;
                        r_state    <= SHIFT;
                    end else begin
                        r_half_cnt <= r_half_cnt + C_CNT_ONE;
                    end
                end

                SHIFT: begin
                    if (r_half_cnt == C_HALF_LAST) begin
                        r_half_cnt <= '0;
                        if (dac_sclk) begin
                            // Falling edge: present the next bit, except after
                            // the last one where there is nothing left to send.
                            dac_sclk <= 1'b0;
                            if (r_bit_cnt != C_LAST_BIT) begin
                                r_shift <= {r_shift[14:0], 1'b0};
                                dac_sdo <= r_shift[14];
                            end
                        end else if (r_bit_cnt == C_LAST_BIT) begin
                            dac_cs_n <= 1'b1;
                            dac_sdo  <= 1'b0;
                            r_state  <= GAP;
                        end else begin
                            dac_sclk  <= 1'b1;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end else begin
                        r_half_cnt <= r_half_cnt + C_CNT_ONE;
                    end
                end

                GAP: begin
                    if (r_half_cnt == C_GAP_LAST) begin
                        r_half_cnt <= '0;
                        busy       <= 1'b0;
                        r_state    <= IDLE;
                    end else begin
                        r_half_cnt <= r_half_cnt + C_CNT_ONE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iir_dac_spi_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iir_dac_spi_tx
//  Purpose  : Self-checking bench for iir_dac_spi_tx. A transaction-level
//             model (pending-sample slot, frame busy window, expected frame
//             queue) predicts busy/cs_n/overrun and the frames; a pin monitor
//             reassembles frames from SCLK rising edges.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_iir_dac_spi_tx;

    localparam int         D    = 2;
    localparam int         GAP  = 4;
    localparam logic [3:0] CMD  = 4'b0011;
    localparam int         FLEN = 33 * D;

    logic        sys_clk   = 1'b0;
    logic        sys_rst   = 1'b0;
    logic [11:0] din       = 12'h000;
    logic        sample_en = 1'b0;
    logic        dac_cs_n;
    logic        dac_sclk;
    logic        dac_sdo;
    logic        busy;
    logic [7:0]  overrun_cnt;

    always #5 sys_clk = ~sys_clk;

    iir_dac_spi_tx #(
        .CLK_DIV (D),
        .CMD     (CMD),
        .CS_GAP  (GAP)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .Din         (din),
        .sample_en   (sample_en),
        .dac_cs_n    (dac_cs_n),
        .dac_sclk    (dac_sclk),
        .dac_sdo     (dac_sdo),
        .busy        (busy),
        .overrun_cnt (overrun_cnt)
    );

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_hold_v;
    logic [11:0] m_hold;
    int          m_busy_left;   // cycles remaining in frame + gap window
    int          m_ovr;
    logic [15:0] exp_q[$];

    task automatic model_reset();
        m_hold_v    = 1'b0;
        m_hold      = 12'h000;
        m_busy_left = 0;
        m_ovr       = 0;
        exp_q.delete();
    endtask

    // Called right at each rising edge with the inputs the DUT samples there.
    task automatic model_edge();
        int v;
        if (!sys_rst) begin
            model_reset();
        end else begin
            if (m_busy_left == 0 && m_hold_v) begin
                v = $signed(m_hold);
                exp_q.push_back({CMD, 12'(v + 2048)});
                m_busy_left = FLEN + GAP;
                m_hold_v    = 1'b0;
            end else if (m_busy_left > 0) begin
                m_busy_left--;
            end
            if (sample_en) begin
                if (m_hold_v && m_ovr < 255) m_ovr++;
                m_hold_v = 1'b1;
                m_hold   = din;
            end
        end
    endtask

    // ---------------- pin monitor ----------------
    logic        p_cs   = 1'b1;
    logic        p_sclk = 1'b0;
    logic        p_sdo  = 1'b0;
    bit          seen_frame = 1'b0;
    int          mon_rises = 0;
    int          mon_low   = 0;
    int          mon_gap   = 0;
    logic [15:0] mon_bits  = 16'h0000;

    task automatic monitor_reset();
        p_cs       = 1'b1;
        p_sclk     = 1'b0;
        p_sdo      = 1'b0;
        seen_frame = 1'b0;
        mon_rises  = 0;
        mon_low    = 0;
        mon_gap    = 0;
        mon_bits   = 16'h0000;
    endtask

    task automatic check_cycle();
        chk("busy", busy, m_busy_left > 0);
        chk("cs_n", dac_cs_n, !(m_busy_left > GAP));
        chk("overrun_cnt", overrun_cnt, m_ovr);
        if (dac_cs_n) begin
            chk("sclk_idle", dac_sclk, 1'b0);
            chk("sdo_idle", dac_sdo, 1'b0);
        end
        if (p_cs && !dac_cs_n) begin
            if (seen_frame) chk("cs_gap_ok", mon_gap >= GAP, 1'b1);
            mon_rises = 0;
            mon_low   = 0;
            mon_bits  = 16'h0000;
        end
        if (!dac_cs_n) begin
            mon_low++;
            if (dac_sclk && !p_sclk) begin
                mon_rises++;
                mon_bits = {mon_bits[14:0], dac_sdo};
            end
            // data must not move in the cycle before a rise nor while SCLK is high
            if (dac_sclk && !p_cs) chk("sdo_stable", dac_sdo, p_sdo);
        end
        if (!p_cs && dac_cs_n) begin
            chk("sclk_rises", mon_rises, 16);
            chk("cs_low_cycles", mon_low, FLEN);
            chk("frame_pending", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) chk("frame", mon_bits, exp_q.pop_front());
            seen_frame = 1'b1;
            mon_gap    = 0;
        end
        if (dac_cs_n) mon_gap++;
        p_cs   = dac_cs_n;
        p_sclk = dac_sclk;
        p_sdo  = dac_sdo;
    endtask

    // One clock: drive at the falling edge, model at the rising edge,
    // check at the next falling edge.
    task automatic step(input logic en, input logic [11:0] d);
        sample_en = en;
        din       = d;
        @(posedge sys_clk);
        model_edge();
        @(negedge sys_clk);
        check_cycle();
    endtask

    task automatic wait_idle(input int max_cycles);
        for (int i = 0; i < max_cycles && (m_busy_left > 0 || m_hold_v); i++) begin
            step(1'b0, 12'($urandom));
        end
        chk("idle_timeout", (m_busy_left > 0 || m_hold_v), 1'b0);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic send_one(input logic [11:0] d);
        step(1'b1, d);
        wait_idle(200);
    endtask

    initial begin
        logic [11:0] seq[4];
        model_reset();
        @(negedge sys_clk);

        // reset held with random inputs
        for (int i = 0; i < 6; i++) begin
            step(1'($urandom), 12'($urandom));
            chk("rst_sclk", dac_sclk, 1'b0);
            chk("rst_sdo", dac_sdo, 1'b0);
        end
        sys_rst = 1'b1;
        step(1'b0, 12'h000);

        // single frames, including the data-mapping corners
        seq[0] = 12'h000; seq[1] = 12'hFFF; seq[2] = 12'h7FF; seq[3] = 12'h800;
        for (int i = 0; i < 4; i++) send_one(seq[i]);
        chk("ovr_after_singles", overrun_cnt, 8'd0);

        // overwrite during a frame
        step(1'b1, 12'h123);
        repeat (10) step(1'b0, 12'($urandom));
        step(1'b1, 12'h0AA);
        repeat (20) step(1'b0, 12'($urandom));
        step(1'b1, 12'h055);
        wait_idle(300);
        chk("ovr_after_overwrite", overrun_cnt, 8'd1);

        // saturation
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 12'($urandom));
            step(1'b0, 12'($urandom));
        end
        chk("ovr_saturated", overrun_cnt, 8'd255);
        wait_idle(300);

        // asynchronous reset mid-frame after the 7th SCLK rise
        step(1'b1, 12'h5A5);
        for (int i = 0; i < 200 && !(mon_rises == 7 && !dac_cs_n); i++) begin
            step(1'b0, 12'($urandom));
        end
        chk("reached_7th_rise", mon_rises, 7);
        #2;
        sys_rst = 1'b0;
        #1;
        chk("mid_rst_cs_n", dac_cs_n, 1'b1);
        chk("mid_rst_sclk", dac_sclk, 1'b0);
        chk("mid_rst_sdo", dac_sdo, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ovr", overrun_cnt, 8'd0);
        model_reset();
        monitor_reset();
        @(negedge sys_clk);
        repeat (3) step(1'($urandom), 12'($urandom));
        sys_rst = 1'b1;
        send_one(12'h400);

        // random traffic with random spacing
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 39) == 0), 12'($urandom));
        end
        wait_idle(300);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
